cpu_bus_ctrl: RTL
=================

Name: cpu_bus_ctrl

Overview:
- Parametrised system-bus controller between `core`, the instruction ROM and the data side.
- Adds configurable ROM fetch latency, an internal data RAM and N memory-mapped output channels.
- Adds a request/ready handshake with stall generation, plus sticky halt detection.
- Replaces the fixed single-output memory controller; `cpu_top` instantiates it in place of that controller.

Parameters:
- ADDR_WIDTH, 5: ROM word-address width; ROM holds 2^ADDR_WIDTH words.
- RAM_ADDR_WIDTH, 6: internal data-RAM word-address width.
- DATA_WIDTH, 32: instruction and data word width.
- OUT_CH, 2: number of memory-mapped output channels.
- OUT_WIDTH, 16: width of each output channel.
- ROM_LAT, 1: ROM read latency in cycles, range 1..4.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: synchronous active-low reset.
- instr_req, in, 1: core requests the fetch at instr_addr.
- instr_addr, in, 32: byte address of the fetch.
- instr_data, out, DATA_WIDTH: fetched instruction.
- instr_valid, out, 1: instr_data is valid this cycle.
- rom_addr, out, ADDR_WIDTH: word address to the ROM.
- rom_q, in, DATA_WIDTH: ROM data, ROM_LAT cycles after rom_addr.
- mem_addr, in, 32: data-side byte address.
- mem_wdata, in, DATA_WIDTH: store data.
- mem_we, in, 1: store request.
- mem_re, in, 1: load request.
- mem_rdata, out, DATA_WIDTH: load data.
- mem_ready, out, 1: data transaction complete, one-cycle pulse.
- stall, out, 1: core must hold its data request.
- halted, out, 1: sticky; fetch went beyond the last ROM word.
- bus_err, out, 1: sticky; unmapped access or we&re collision.
- data_out, out, OUT_CH*OUT_WIDTH: output channels; channel k occupies bits [k*OUT_WIDTH +: OUT_WIDTH].

Behaviour:
- Reset: rst_n low at a clk edge forces every output to 0 and clears the output registers, fetch pipeline, FSM state, halted and bus_err. An in-flight transaction is dropped with no ready pulse. RAM contents are not cleared.
- Fetch path:
  - rom_addr = instr_addr[ADDR_WIDTH+1:2], combinational.
  - A ROM_LAT-deep valid shift register tracks requests; instr_valid rises exactly ROM_LAT cycles after instr_req. Back-to-back requests give one valid per cycle.
  - If instr_addr[31:ADDR_WIDTH+2] is nonzero, instr_data = 0 (NOP) and halted sets on the cycle the fetch completes. halted clears only on reset.
- Address map (decode on mem_addr[31:28]):
  - 0x0: RAM, word index mem_addr[RAM_ADDR_WIDTH+1:2]; higher bits are ignored (aliasing).
  - 0x8: output channel k = mem_addr[7:2] for k < OUT_CH; channel takes mem_wdata[OUT_WIDTH-1:0]; reads return the zero-extended register.
  - Anything else is unmapped: writes are ignored, reads return 0, bus_err sets.
- Data FSM:
  - IDLE:
    - mem_we: perform the write at this edge, go to RESP.
    - mem_re to RAM: go to RD.
    - mem_re to IO or unmapped: latch the value, go to RESP.
  - RD: RAM output is available; latch it into mem_rdata; go to RESP.
  - RESP: mem_ready = 1 for one cycle; go to IDLE. A new request is sampled the cycle after RESP.
  - stall = 1 whenever the state is not IDLE, or when the state is IDLE and mem_we|mem_re is asserted.
- Latency: store 2 cycles request-to-ready; RAM load 3 cycles; IO load 2 cycles.
- mem_rdata holds its value until the next load completes.
- mem_we and mem_re together: write wins, no read is performed, bus_err sets.
- Requests are sampled only in IDLE; the core must hold address and data while stall = 1.
- The fetch and data paths are independent and may be active in the same cycle.

Optional Feature:
- Macro: CPU_BUS_PERF_EN.
- Defined: 32-bit counter of completed data transactions (increments at each RESP), wraps at 2^32, reset to 0. Readable at 0x8000_0100 (read-only; writes there are ignored without bus_err).
- Undefined: 0x8000_0100 is unmapped, so reads return 0 and set bus_err.

Decomposition:
- Package cpu_bus_pkg holds:
  - region constants: REG_RAM = 4'h0, REG_IO = 4'h8;
  - PERF_OFFSET = 8'h40 (word offset);
  - the FSM state enum {IDLE, RD, RESP}, 2 bits.
- One sub-module: cpu_ram_sp, a single-port synchronous RAM (1-cycle read, write-first) parametrised by RAM_ADDR_WIDTH and DATA_WIDTH.

Test Plan:
- ROM_LAT=3, instr_req pulses at addrs 0,4,8 on consecutive cycles -> instr_valid on cycles 3,4,5 carrying rom words 0,1,2.
- Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 -> mem_ready 2 cycles after the store request, 3 after the load; mem_rdata = 0xDEADBEEF; stall high throughout each transaction.
- Store 0x1234 to 0x8000_0004 with OUT_CH=2 -> data_out[31:16] = 0x1234, data_out[15:0] unchanged.
- Fetch at instr_addr 0x80 with ADDR_WIDTH=5 -> instr_data = 0, halted = 1 and remains 1 until rst_n low.
- mem_we & mem_re together to 0x8000_0000, then a store to 0x4000_0000 -> first: write done and bus_err = 1; second: no state change and bus_err still 1.
- Store in flight, rst_n low for one cycle -> no mem_ready; data_out = 0, stall = 0. With CPU_BUS_PERF_EN: perf counter reads 0 afterwards, then 1 after one further store.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared constants and FSM state type for cpu_bus_ctrl
package cpu_bus_pkg;

    localparam logic [3:0] REG_RAM     = 4'h0;
    localparam logic [3:0] REG_IO      = 4'h8;
    localparam logic [7:0] PERF_OFFSET = 8'h40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RESP = 2'd2
    } bus_state_t;

endpackage

// File: rtl/cpu_ram_sp.sv
// rtl/cpu_ram_sp.sv - single-port synchronous data RAM, 1-cycle read, write-first
module cpu_ram_sp #(
    parameter int RAM_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [RAM_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<RAM_ADDR_WIDTH)-1];

    // Write-first port: a write returns the new word on rdata the next cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - system-bus controller (ROM fetch, data RAM, output channels); option CPU_BUS_PERF_EN
module cpu_bus_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int RAM_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int OUT_CH         = 2,
    parameter int OUT_WIDTH      = 16,
    parameter int ROM_LAT        = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        instr_req,
    input  logic [31:0]                 instr_addr,
    output logic [DATA_WIDTH-1:0]       instr_data,
    output logic                        instr_valid,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    input  logic [DATA_WIDTH-1:0]       rom_q,
    input  logic [31:0]                 mem_addr,
    input  logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic                        mem_we,
    input  logic                        mem_re,
    output logic [DATA_WIDTH-1:0]       mem_rdata,
    output logic                        mem_ready,
    output logic                        stall,
    output logic                        halted,
    output logic                        bus_err,
    output logic [OUT_CH*OUT_WIDTH-1:0] data_out
);

    // ---------------- fetch path ----------------
    logic [ROM_LAT-1:0] vld_sr;
    logic [ROM_LAT-1:0] oob_sr;
    logic               halted_r;
    logic               fetch_oob;

    assign rom_addr  = instr_addr[ADDR_WIDTH+1:2];
    assign fetch_oob = |instr_addr[31:ADDR_WIDTH+2];

    // Track outstanding fetches and whether each one fell beyond the ROM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_sr   <= '0;
            oob_sr   <= '0;
            halted_r <= 1'b0;
        end else begin
            vld_sr[0] <= instr_req;
            oob_sr[0] <= instr_req & fetch_oob;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                oob_sr[i] <= oob_sr[i-1];
            end
            halted_r <= halted;
        end
    end

    assign instr_valid = vld_sr[ROM_LAT-1];
    assign instr_data  = (instr_valid && !oob_sr[ROM_LAT-1]) ? rom_q : '0;
    assign halted      = halted_r | (instr_valid & oob_sr[ROM_LAT-1]);

    // ---------------- data path ----------------
    bus_state_t                          state_q, state_d;
    logic [OUT_CH-1:0][OUT_WIDTH-1:0]    chan_r;
    logic [DATA_WIDTH-1:0]               rdata_r;
    logic [DATA_WIDTH-1:0]               io_rdata;
    logic [DATA_WIDTH-1:0]               ram_q;
    logic                                bus_err_r;
    logic [3:0]                          region;
    logic [25:0]                         io_off;
    logic                                is_ram, is_chan, is_perf, mapped;
    logic                                req, accept, ram_we;
    logic                                unused_bits;

    assign region  = mem_addr[31:28];
    assign io_off  = mem_addr[27:2];
    assign is_ram  = (region == REG_RAM);
    assign is_chan = (region == REG_IO) && (io_off < 26'(OUT_CH));
`ifdef CPU_BUS_PERF_EN
    logic [31:0] perf_cnt;
    assign is_perf = (region == REG_IO) && (io_off == 26'(PERF_OFFSET));

    // Count completed data transactions, wrapping naturally
    always_ff @(posedge clk) begin
        if (!rst_n)
            perf_cnt <= '0;
        else if (state_q == RESP)
            perf_cnt <= perf_cnt + 32'd1;
    end
`else
    assign is_perf = 1'b0;
`endif
    assign mapped  = is_ram | is_chan | is_perf;
    assign req     = mem_we | mem_re;
    assign accept  = (state_q == IDLE) && req;
    assign ram_we  = rst_n & accept & mem_we & is_ram;

    assign unused_bits = ^{mem_addr[1:0], instr_addr[1:0]};

    cpu_ram_sp #(
        .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (mem_addr[RAM_ADDR_WIDTH+1:2]),
        .wdata (mem_wdata),
        .rdata (ram_q)
    );

    // Read value for IO-space and unmapped loads (zero unless a register matches)
    always_comb begin
        io_rdata = '0;
        for (int k = 0; k < OUT_CH; k++) begin
            if (is_chan && io_off == 26'(k))
                io_rdata = DATA_WIDTH'(chan_r[k]);
        end
`ifdef CPU_BUS_PERF_EN
        if (is_perf)
            io_rdata = DATA_WIDTH'(perf_cnt);
`endif
    end

    // Data FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state: only RAM loads need the extra RD cycle for the RAM output
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req)
                    state_d = (mem_re && !mem_we && is_ram) ? RD : RESP;
            end
            RD:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output channels, load data latch and sticky bus error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chan_r    <= '0;
            rdata_r   <= '0;
            bus_err_r <= 1'b0;
        end else begin
            if (accept) begin
                for (int k = 0; k < OUT_CH; k++) begin
                    if (mem_we && is_chan && io_off == 26'(k))
                        chan_r[k] <= mem_wdata[OUT_WIDTH-1:0];
                end
                if ((mem_we && mem_re) || !mapped)
                    bus_err_r <= 1'b1;
                if (!mem_we && !is_ram)
                    rdata_r <= io_rdata;
            end
            if (state_q == RD)
                rdata_r <= ram_q;
        end
    end

    assign mem_ready = (state_q == RESP);
    assign stall     = (state_q != IDLE) | req;
    assign mem_rdata = rdata_r;
    assign bus_err   = bus_err_r;
    assign data_out  = chan_r;

endmodule
